fan_speed_ctrl: RTL and testbench

Sequencing controller for the fan PWM generator. It accepts a requested duty-cycle target over a valid/ready handshake. It kicks a stopped fan at full duty, then slews the 8-bit `speed` word one LSB at a time toward the target. Its `speed` output drives the `speed` input of the PWM stage directly. The PWM stage treats the word as a duty cycle in 256ths.

---
 rtl/fan_speed_ctrl_pkg.sv | 28 ++
 rtl/fan_speed_ctrl_step_timer.sv | 40 ++++
 rtl/fan_speed_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_fan_speed_ctrl.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/fan_speed_ctrl_pkg.sv
// Shared definitions for the fan speed sequencer: state encoding,
// default duty constants and the target clamp rule.
package fan_speed_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_KICK  = 3'd1,
    ST_RAMP  = 3'd2,
    ST_HOLD  = 3'd3,
    ST_FAULT = 3'd4
  } state_e;

  localparam logic [7:0] MIN_SPEED_DEF  = 8'd64;
  localparam logic [7:0] KICK_SPEED_DEF = 8'd255;

  // Zero stays zero (stop); small non-zero requests are raised to the
  // lowest duty at which the fan keeps turning.
  function automatic logic [7:0] clamp_tgt(input logic [7:0] t, input logic [7:0] min_spd);
    if (t == 8'd0) begin
      return 8'd0;
    end else if (t < min_spd) begin
      return min_spd;
    end else begin
      return t;
    end
  endfunction

endpackage

// File: rtl/fan_speed_ctrl_step_timer.sv
// fan_step_timer: modulo-MOD cycle counter with synchronous clear.
// tick is high in the last cycle of each period, so the owner acts on
// the same edge at which the counter wraps.
module fan_step_timer #(
  parameter int unsigned MOD = 256
) (
  input  logic clk,
  input  logic arst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int unsigned CW = (MOD > 1) ? $clog2(MOD) : 1;

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign tick = en && !clr && (cnt_q == CW'(MOD - 1));

  // Next count: clear wins, otherwise advance and wrap while enabled
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = tick ? '0 : cnt_q + 1'b1;
    end
  end

  // Counter register
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/fan_speed_ctrl.sv
// fan_speed_ctrl: kicks a stopped fan at full duty, then slews the PWM
// duty word one LSB per STEP_DIV cycles toward the accepted target.
// Optional tach-loss monitor enabled with `define FAN_TACH_EN.
module fan_speed_ctrl
  import fan_speed_ctrl_pkg::*;
#(
  parameter int unsigned STEP_DIV     = 256,
  parameter int unsigned KICK_CYCLES  = 1024,
  parameter logic [7:0]  KICK_SPEED   = KICK_SPEED_DEF,
  parameter logic [7:0]  MIN_SPEED    = MIN_SPEED_DEF,
  parameter int unsigned TACH_TIMEOUT = 65535
) (
  input  logic       clk,
  input  logic       arst,
  input  logic       enable,
  input  logic       tgt_valid,
  output logic       tgt_ready,
  input  logic [7:0] tgt_speed,
  input  logic       tach,
  output logic [7:0] speed,
  output logic       busy,
  output logic       fault
);

  state_e     state_q, state_d;
  logic [7:0] speed_q, speed_d;
  logic [7:0] tgt_q, tgt_d;
  logic       busy_q, busy_d;
  logic       accept;
  logic       step_tick, kick_tick;
  logic       step_clr, kick_clr;
  logic       tach_timeout;

  assign tgt_ready = enable && (state_q != ST_KICK) && (state_q != ST_FAULT);
  assign accept    = tgt_valid && tgt_ready;
  assign speed     = speed_q;
  assign busy      = busy_q;

  // Both timers sit at zero outside their own state, so every entry starts a fresh period
  assign step_clr = !enable || (state_q != ST_RAMP);
  assign kick_clr = !enable || (state_q != ST_KICK);

  fan_step_timer #(.MOD(STEP_DIV)) u_step_timer (
    .clk  (clk),
    .arst (arst),
    .clr  (step_clr),
    .en   (state_q == ST_RAMP),
    .tick (step_tick)
  );

  fan_step_timer #(.MOD(KICK_CYCLES)) u_kick_timer (
    .clk  (clk),
    .arst (arst),
    .clr  (kick_clr),
    .en   (state_q == ST_KICK),
    .tick (kick_tick)
  );

`ifdef FAN_TACH_EN
  localparam int unsigned TW = $clog2(TACH_TIMEOUT + 1);

  logic [TW-1:0] tach_cnt_q, tach_cnt_d;
  logic          tach_prev_q, tach_prev_d;
  logic          fault_q, fault_d;
  logic          tach_mon;

  assign tach_mon     = (state_q == ST_RAMP) || (state_q == ST_HOLD);
  assign tach_timeout = tach_mon && (tach_cnt_q == TW'(TACH_TIMEOUT));
  assign tach_prev_d  = tach;
  assign fault_d      = (state_d == ST_FAULT);
  assign fault        = fault_q;

  // Cycles since the last tach rising edge; restarts on any state change
  always_comb begin
    tach_cnt_d = tach_cnt_q;
    if (!tach_mon || (state_d != state_q) || (tach && !tach_prev_q)) begin
      tach_cnt_d = '0;
    end else if (tach_cnt_q != TW'(TACH_TIMEOUT)) begin
      tach_cnt_d = tach_cnt_q + 1'b1;
    end
  end

  // Tach monitor registers
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      tach_cnt_q  <= '0;
      tach_prev_q <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      tach_cnt_q  <= tach_cnt_d;
      tach_prev_q <= tach_prev_d;
      fault_q     <= fault_d;
    end
  end
`else
  localparam int unsigned tach_timeout_unused = TACH_TIMEOUT;
  logic tach_unused;

  assign tach_unused  = tach;
  assign tach_timeout = 1'b0;
  assign fault        = 1'b0;
`endif

  // Next state, duty word and target register
  always_comb begin
    state_d = state_q;
    speed_d = speed_q;
    tgt_d   = tgt_q;
    if (state_q == ST_FAULT) begin
      speed_d = 8'hFF;
    end else if (tach_timeout) begin
      state_d = ST_FAULT;
      speed_d = 8'hFF;
    end else if (!enable) begin
      state_d = ST_IDLE;
      speed_d = 8'd0;
      tgt_d   = 8'd0;
    end else begin
      if (accept) begin
        tgt_d = clamp_tgt(tgt_speed, MIN_SPEED);
      end
      case (state_q)
        ST_IDLE: begin
          speed_d = 8'd0;
          if (accept && (tgt_d != 8'd0)) begin
            state_d = ST_KICK;
            speed_d = KICK_SPEED;
          end
        end
        ST_KICK: begin
          speed_d = KICK_SPEED;
          if (kick_tick) begin
            speed_d = MIN_SPEED;
            state_d = (tgt_q == MIN_SPEED) ? ST_HOLD : ST_RAMP;
          end
        end
        ST_RAMP: begin
          if (step_tick) begin
            if ((tgt_q == 8'd0) && (speed_q == MIN_SPEED)) begin
              speed_d = 8'd0;
              state_d = ST_IDLE;
              if (accept && (tgt_d != 8'd0)) begin
                state_d = ST_KICK;
                speed_d = KICK_SPEED;
              end
            end else if (speed_q < tgt_q) begin
              speed_d = speed_q + 8'd1;
            end else if (speed_q > tgt_q) begin
              speed_d = speed_q - 8'd1;
            end
          end
          if ((state_d == ST_RAMP) && (speed_d == tgt_d)) begin
            state_d = ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (accept && (tgt_d != speed_q)) begin
            state_d = ST_RAMP;
          end
        end
        default: begin
          state_d = ST_IDLE;
          speed_d = 8'd0;
        end
      endcase
    end
    busy_d = (state_d == ST_KICK) || (state_d == ST_RAMP);
  end

  // Control and output registers
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q <= ST_IDLE;
      speed_q <= 8'd0;
      tgt_q   <= 8'd0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      speed_q <= speed_d;
      tgt_q   <= tgt_d;
      busy_q  <= busy_d;
    end
  end

endmodule

// File: tb/tb_fan_speed_ctrl.sv
// Directed bench for fan_speed_ctrl with STEP_DIV=4, KICK_CYCLES=8,
// MIN_SPEED=64, KICK_SPEED=255, TACH_TIMEOUT=50.
module tb_fan_speed_ctrl;

  logic       clk = 1'b0;
  logic       arst = 1'b1;
  logic       enable = 1'b1;
  logic       tgt_valid = 1'b0;
  logic       tgt_ready;
  logic [7:0] tgt_speed = 8'd0;
  logic       tach = 1'b0;
  logic [7:0] speed;
  logic       busy;
  logic       fault;
  logic       tach_stuck = 1'b0;
  int         tach_div = 0;
  int         tests = 0;
  int         failed = 0;

  fan_speed_ctrl #(
    .STEP_DIV     (4),
    .KICK_CYCLES  (8),
    .KICK_SPEED   (8'd255),
    .MIN_SPEED    (8'd64),
    .TACH_TIMEOUT (50)
  ) dut (
    .clk       (clk),
    .arst      (arst),
    .enable    (enable),
    .tgt_valid (tgt_valid),
    .tgt_ready (tgt_ready),
    .tgt_speed (tgt_speed),
    .tach      (tach),
    .speed     (speed),
    .busy      (busy),
    .fault     (fault)
  );

  always #5 clk = ~clk;

  // Healthy fan: one tach edge every 4 cycles unless the test jams it low
  always @(negedge clk) begin
    tach_div = tach_div + 1;
    if (tach_stuck) tach = 1'b0;
    else if (tach_div % 4 == 0) tach = ~tach;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests = tests + 1;
    assert (obs === exp) else begin
      failed = failed + 1;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic offer(input logic [7:0] t);
    tgt_valid = 1'b1;
    tgt_speed = t;
    tick(1);
    tgt_valid = 1'b0;
  endtask

  initial begin
    int n;
    // reset
    tick(2);
    chk("rst_speed", speed, 0);
    arst = 1'b0;
    tick(1);
    chk("rst_speed2", speed, 0);
    chk("rst_ready", tgt_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_fault", fault, 0);

    // target 100 from IDLE: kick 8 cycles, then ramp 64 -> 100
    offer(8'd100);
    chk("k100_busy", busy, 1);
    chk("k100_ready", tgt_ready, 0);
    for (int i = 0; i < 8; i++) begin
      chk("k100_kick", speed, 255);
      tick(1);
    end
    chk("k100_min", speed, 64);
    chk("k100_ramp_busy", busy, 1);
    chk("k100_ramp_ready", tgt_ready, 1);
    tick(3);
    chk("k100_pre_step", speed, 64);
    tick(1);
    chk("k100_step1", speed, 65);
    tick(139);
    chk("k100_99", speed, 99);
    chk("k100_99_busy", busy, 1);
    tick(1);
    chk("k100_reach", speed, 100);
    chk("k100_hold_busy", busy, 0);
    tick(4);
    chk("k100_hold", speed, 100);

    // HOLD 100 -> 80: 20 down-steps over 80 cycles
    offer(8'd80);
    chk("d80_start", speed, 100);
    chk("d80_busy", busy, 1);
    tick(79);
    chk("d80_81", speed, 81);
    tick(1);
    chk("d80_reach", speed, 80);
    chk("d80_busy_end", busy, 0);

    // HOLD 80 -> 0: ramp to 64, then drop straight to 0
    offer(8'd0);
    tick(64);
    chk("d0_min", speed, 64);
    chk("d0_min_busy", busy, 1);
    tick(3);
    chk("d0_min_hold", speed, 64);
    tick(1);
    chk("d0_zero", speed, 0);
    chk("d0_busy", busy, 0);
    chk("d0_ready", tgt_ready, 1);
    tick(6);
    chk("d0_idle", speed, 0);

    // target 10 clamps to 64: kick then straight to HOLD
    offer(8'd10);
    for (int i = 0; i < 8; i++) begin
      chk("k10_kick", speed, 255);
      tick(1);
    end
    chk("k10_min", speed, 64);
    chk("k10_busy", busy, 0);
    chk("k10_tgt", dut.tgt_q, 64);
    tick(4);
    chk("k10_hold", speed, 64);

    // target 20 in HOLD clamps to current speed: stays in HOLD
    offer(8'd20);
    chk("eq_busy", busy, 0);
    tick(4);
    chk("eq_speed", speed, 64);

    // ramp toward 200, then enable low with a simultaneous offer
    offer(8'd200);
    tick(8);
    chk("r200_66", speed, 66);
    enable = 1'b0;
    tgt_valid = 1'b1;
    tgt_speed = 8'd150;
    #1;
    chk("en_ready", tgt_ready, 0);
    tick(1);
    tgt_valid = 1'b0;
    chk("en_speed", speed, 0);
    chk("en_busy", busy, 0);
    chk("en_tgt", dut.tgt_q, 0);
    enable = 1'b1;
    tick(3);
    chk("en_idle", speed, 0);
    chk("en_ready2", tgt_ready, 1);

    // asynchronous reset in the middle of a kick
    offer(8'd150);
    chk("ar_kick", speed, 255);
    tick(3);
    #2 arst = 1'b1;
    #1;
    chk("ar_speed", speed, 0);
    chk("ar_busy", busy, 0);
    chk("ar_tgt", dut.tgt_q, 0);
    #1 arst = 1'b0;
    tick(1);
    chk("ar_ready", tgt_ready, 1);
    tick(10);
    chk("ar_idle", speed, 0);

`ifdef FAN_TACH_EN
    // tach jammed low in HOLD: fault 51 edges after entering HOLD
    tach_stuck = 1'b1;
    offer(8'd64);
    tick(8);
    chk("tf_hold", speed, 64);
    n = 0;
    while (!fault && n < 200) begin
      tick(1);
      n = n + 1;
    end
    chk("tf_cycles", n, 51);
    chk("tf_speed", speed, 255);
    chk("tf_ready", tgt_ready, 0);
    chk("tf_busy", busy, 0);
    enable = 1'b0;
    tick(2);
    chk("tf_sticky", fault, 1);
    chk("tf_sticky_speed", speed, 255);
    enable = 1'b1;
    #2 arst = 1'b1;
    #1;
    chk("tf_clear", fault, 0);
    arst = 1'b0;
    tach_stuck = 1'b0;
`else
    n = 0;
    tach_stuck = 1'b1;
    offer(8'd64);
    tick(80);
    chk("nt_fault", fault, n);
    chk("nt_hold", speed, 64);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
